// File: rtl/wb_burst_sram_if.sv
// Wishbone B4 bus bundle between the core's master (via wb_intercon) and the dmem slave.
// Clock and reset travel as plain ports alongside it.
interface wb_burst_sram_if;
  logic [31:0] adr;
  logic [31:0] dat_wr;
  logic [31:0] dat_rd;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    output adr, dat_wr, sel, we, cyc, stb, cti, bte,
    input  dat_rd, ack, err, rty
  );

  modport slave (
    input  adr, dat_wr, sel, we, cyc, stb, cti, bte,
    output dat_rd, ack, err, rty
  );
endinterface

// File: rtl/wb_burst_sram.sv
// Wishbone B4 data-memory slave: single accesses with programmable wait states and
// CTI incrementing bursts (linear / wrap-4/8/16), byte-lane writes, err on out-of-range words.
module wb_burst_sram #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input logic            wb_clk_i,
  input logic            wb_rst_i,
  wb_burst_sram_if.slave wb
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, BURST} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  logic [29:0] addr_cnt_reg, addr_cnt_next;
  logic [2:0]  cti_reg, cti_next;
  logic [1:0]  bte_reg, bte_next;

  logic [31:0] mem [DEPTH];
  logic [31:0] rd_data_reg;

  logic        bus_req;
  logic        burst_cti_ok;
  logic        beat;
  logic        in_range;
  logic        ack;
  logic        wr_commit;
  logic [3:0]  lane_we;
  logic [29:0] addr_inc;
  logic [29:0] rd_addr;
  logic        unused_bits;

  assign bus_req      = wb.cyc & wb.stb;
  assign burst_cti_ok = (wb.cti == 3'b010) || (wb.cti == 3'b111);
  assign in_range     = ({2'b00, addr_cnt_reg} < 32'(DEPTH));

  // A beat terminates (ack or err) in RESP, or in BURST whenever the master strobes a burst beat.
  assign beat = ~wb_rst_i & bus_req &
                ((state_reg == RESP) || ((state_reg == BURST) && burst_cti_ok));

  assign ack       = beat & in_range;
  assign wr_commit = ack & wb.we;

  assign wb.ack    = ack;
  assign wb.err    = beat & ~in_range;
  assign wb.rty    = 1'b0;
  assign wb.dat_rd = ack ? rd_data_reg : 32'h0;

  // Wrapping bursts only advance the low 2/3/4 bits; the upper bits stay pinned.
  always_comb begin
    addr_inc = addr_cnt_reg + 30'd1;
    case (bte_reg)
      2'b01:   addr_inc = {addr_cnt_reg[29:2], addr_cnt_reg[1:0] + 2'd1};
      2'b10:   addr_inc = {addr_cnt_reg[29:3], addr_cnt_reg[2:0] + 3'd1};
      2'b11:   addr_inc = {addr_cnt_reg[29:4], addr_cnt_reg[3:0] + 4'd1};
      default: addr_inc = addr_cnt_reg + 30'd1;
    endcase
  end

  // Reading the post-increment address on a beat edge prefetches the next burst word.
  assign rd_addr     = beat ? addr_inc : addr_cnt_reg;
  assign unused_bits = ^{wb.adr[1:0], rd_addr[29:AW]};

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    addr_cnt_next = addr_cnt_reg;
    cti_next      = cti_reg;
    bte_next      = bte_reg;

    if (beat) begin
      addr_cnt_next = addr_inc;
    end

    case (state_reg)
      IDLE: begin
        if (bus_req) begin
          state_next    = WAIT;
          wait_cnt_next = 4'(WAIT_STATES);
          addr_cnt_next = wb.adr[31:2];
          cti_next      = wb.cti;
          bte_next      = wb.bte;
        end
      end
      // WAIT lasts WAIT_STATES+1 cycles; the extra cycle is the synchronous RAM read.
      WAIT: begin
        if (wait_cnt_reg == 4'd0) begin
          state_next = RESP;
        end else begin
          wait_cnt_next = wait_cnt_reg - 4'd1;
        end
      end
      RESP: begin
        if ((cti_reg == 3'b010) && bus_req) begin
          state_next = BURST;
        end else begin
          state_next = IDLE;
        end
      end
      BURST: begin
        if (bus_req && !burst_cti_ok) begin
          state_next = IDLE;
        end else if (beat && (wb.cti == 3'b111)) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    if (!wb.cyc) begin
      state_next = IDLE;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_reg    <= IDLE;
      wait_cnt_reg <= 4'd0;
      addr_cnt_reg <= 30'd0;
      cti_reg      <= 3'b000;
      bte_reg      <= 2'b00;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      addr_cnt_reg <= addr_cnt_next;
      cti_reg      <= cti_next;
      bte_reg      <= bte_next;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign lane_we[gi] = wr_commit & wb.sel[gi];
  end

  always_ff @(posedge wb_clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (lane_we[b]) begin
        mem[addr_cnt_reg[AW-1:0]][8*b +: 8] <= wb.dat_wr[8*b +: 8];
      end
    end
    rd_data_reg <= mem[rd_addr[AW-1:0]];
  end

endmodule

// File: tb/tb_wb_burst_sram.sv
// Self-checking bench for wb_burst_sram: a zero-wait and a three-wait instance share one
// driver; a word-array model with arithmetic burst addressing supplies every expectation.
module tb_wb_burst_sram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        cyc, stb, we;
  logic [31:0] adr, dat;
  logic [3:0]  sel;
  logic [2:0]  cti;
  logic [1:0]  bte;
  bit          use3;

  wb_burst_sram_if bus0();
  wb_burst_sram_if bus3();

  assign bus0.cyc = cyc & ~use3;   assign bus3.cyc = cyc & use3;
  assign bus0.stb = stb & ~use3;   assign bus3.stb = stb & use3;
  assign bus0.we = we;             assign bus3.we = we;
  assign bus0.adr = adr;           assign bus3.adr = adr;
  assign bus0.dat_wr = dat;        assign bus3.dat_wr = dat;
  assign bus0.sel = sel;           assign bus3.sel = sel;
  assign bus0.cti = cti;           assign bus3.cti = cti;
  assign bus0.bte = bte;           assign bus3.bte = bte;

  wb_burst_sram #(.DEPTH(1024), .WAIT_STATES(0)) dut0 (.wb_clk_i(clk), .wb_rst_i(rst), .wb(bus0));
  wb_burst_sram #(.DEPTH(1024), .WAIT_STATES(3)) dut3 (.wb_clk_i(clk), .wb_rst_i(rst), .wb(bus3));

  logic        ack, err;
  logic [31:0] rdat;
  assign ack  = use3 ? bus3.ack : bus0.ack;
  assign err  = use3 ? bus3.err : bus0.err;
  assign rdat = use3 ? bus3.dat_rd : bus0.dat_rd;

  int errors = 0;
  int checks = 0;
  int cyc_cnt = 0;
  bit mon_en = 1'b0;
  logic [31:0] model [2][1024];

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Ack/err exclusivity, silence while cyc is low, rty stuck at 0.
  always @(negedge clk) begin
    if (mon_en) begin
      check("protocol", 32'((bus0.ack & bus0.err) | (bus3.ack & bus3.err) |
                            (~bus0.cyc & (bus0.ack | bus0.err)) |
                            (~bus3.cyc & (bus3.ack | bus3.err)) | bus0.rty | bus3.rty), 32'h0);
    end
  end

  function automatic int wait_of(input bit u);
    return u ? 3 : 0;
  endfunction

  function automatic int baddr(input int start, input logic [1:0] b, input int k);
    int n;
    if (b == 2'b00) return start + k;
    n = 2 << b;
    return (start & ~(n - 1)) | ((start + k) & (n - 1));
  endfunction

  task automatic mwrite(input bit u, input int a, input logic [3:0] s, input logic [31:0] d);
    for (int b = 0; b < 4; b++) begin
      if (s[b]) model[u][a][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic classic(input bit u, input bit w, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, input logic [2:0] c,
                         output bit gack, output bit gerr, output logic [31:0] gdat, output int lat);
    bit done;
    use3 = u;
    tick();
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; sel = s; dat = d; cti = c; bte = 2'($urandom);
    lat = 0; gack = 1'b0; gerr = 1'b0; gdat = 32'h0; done = 1'b0;
    while (!done && lat <= 40) begin
      @(negedge clk);
      if (ack || err) begin
        gack = ack; gerr = err; gdat = rdat; done = 1'b1;
      end else begin
        @(posedge clk);
        #1;
        lat++;
      end
    end
    tick();
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    check("ack_drop", 32'(ack | err), 32'h0);
  endtask

  task automatic classic_model(input bit u, input bit w, input logic [31:0] a,
                               input logic [3:0] s, input logic [31:0] d, input logic [2:0] c);
    bit ga, ge;
    logic [31:0] gd;
    int lat, word;
    bit e;
    word = int'(a[31:2]);
    e = (a[31:2] >= 30'd1024);
    classic(u, w, a, s, d, c, ga, ge, gd, lat);
    $display("classic u=%0d we=%0d adr=%h sel=%h ack=%0d err=%0d dat=%h lat=%0d", u, w, a, s, ga, ge, gd, lat);
    check("cl_ack", 32'(ga), 32'(!e));
    check("cl_err", 32'(ge), 32'(e));
    check("cl_lat", 32'(lat), 32'(2 + wait_of(u)));
    if (!w) check("cl_dat", gd, e ? 32'h0 : model[u][word]);
    if (w && !e) mwrite(u, word, s, d);
  endtask

  task automatic burst(input bit u, input bit w, input int start, input logic [1:0] b, input int n,
                       input int gap_after, input int gap_len, input int abort_after, input bit rnd_sel);
    int k, lat, stall, a, first_cyc, last_cyc;
    logic [31:0] d;
    logic [3:0] s;
    bit done;
    use3 = u;
    tick();
    d = $urandom;
    s = rnd_sel ? 4'($urandom) : 4'hF;
    cyc = 1'b1; stb = 1'b1; we = w; adr = 32'(start) << 2; bte = b; dat = d; sel = s;
    cti = (n == 1) ? 3'b111 : 3'b010;
    k = 0; lat = 0; stall = 0; done = 1'b0; first_cyc = 0; last_cyc = 0;
    while (!done) begin
      @(negedge clk);
      if (ack || err) begin
        a = baddr(start, b, k);
        if (k == 0) begin
          check("bu_lat", 32'(lat), 32'(2 + wait_of(u)));
          first_cyc = cyc_cnt;
        end
        last_cyc = cyc_cnt;
        check("bu_err", 32'(err), 32'(a >= 1024));
        if (!w || a >= 1024) check("bu_dat", rdat, (a >= 1024) ? 32'h0 : model[u][a]);
        if (w && a < 1024) mwrite(u, a, s, d);
        k++;
        stall = 0;
        tick();
        if (k == n) begin
          cyc = 1'b0; stb = 1'b0; done = 1'b1;
        end else begin
          if (k - 1 == gap_after) begin
            stb = 1'b0;
            repeat (gap_len) begin
              @(negedge clk);
              check("gap_quiet", 32'(ack | err), 32'h0);
              tick();
            end
            stb = 1'b1;
          end
          d = $urandom;
          s = rnd_sel ? 4'($urandom) : 4'hF;
          dat = d; sel = s; adr = $urandom;
          cti = (k == n - 1) ? 3'b111 : 3'b010;
          if (k - 1 == abort_after) begin
            rst = 1'b1;
            @(negedge clk);
            check("rst_noack", 32'(ack | err), 32'h0);
            tick();
            rst = 1'b0; cyc = 1'b0; stb = 1'b0; done = 1'b1;
          end
        end
      end else begin
        if (k == 0) lat++;
        stall++;
        if (stall > 60) begin
          check("bu_timeout", 32'(stall), 32'h0);
          cyc = 1'b0; stb = 1'b0; done = 1'b1;
        end
        tick();
      end
    end
    $display("burst u=%0d we=%0d start=%0d bte=%0d n=%0d beats_done=%0d", u, w, start, b, n, k);
    if (abort_after < 0 && k == n) begin
      check("bu_b2b", 32'(last_cyc - first_cyc),
            32'(n - 1 + ((gap_after >= 0 && gap_after < n - 1) ? gap_len : 0)));
    end
  endtask

  typedef struct {
    bit          u;
    bit          we;
    logic [31:0] adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [31:0] exp_dat;
    bit          exp_err;
  } vec_t;

  vec_t tbl [15];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ga, ge;
    logic [31:0] gd;
    int lat, g;
    bit u, w;
    logic [1:0] b;
    int n, st;

    tbl[0]  = '{1'b0, 1'b1, 32'h10,   4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 1'b0, 32'h10,   4'hF, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 32'h0,    4'hF, 32'h11223344, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 1'b1, 32'h0,    4'h2, 32'h0000AA00, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,    4'hF, 32'h0,        32'h1122AA44, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 32'h0,    4'hF, 32'h0BADF00D, 32'h0,        1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h1000, 4'hF, 32'h12345678, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 1'b0, 32'h1000, 4'hF, 32'h0,        32'h0,        1'b1};
    tbl[8]  = '{1'b0, 1'b0, 32'h0,    4'hF, 32'h0,        32'h0BADF00D, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 32'hFFC,  4'hF, 32'h01020304, 32'h0,        1'b0};
    tbl[10] = '{1'b0, 1'b1, 32'hFFC,  4'h0, 32'hFFFFFFFF, 32'h0,        1'b0};
    tbl[11] = '{1'b0, 1'b0, 32'hFFC,  4'hF, 32'h0,        32'h01020304, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 32'h40,   4'hF, 32'h00000000, 32'h0,        1'b0};
    tbl[13] = '{1'b0, 1'b1, 32'h40,   4'h9, 32'hAABBCCDD, 32'h0,        1'b0};
    tbl[14] = '{1'b0, 1'b0, 32'h40,   4'hF, 32'h0,        32'hAA0000DD, 1'b0};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = 32'h0; dat = 32'h0;
    sel = 4'h0; cti = 3'b000; bte = 2'b00; use3 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_ack0", 32'(bus0.ack | bus0.err), 32'h0);
    check("rst_dat0", bus0.dat_rd, 32'h0);
    check("rst_ack3", 32'(bus3.ack | bus3.err), 32'h0);
    check("rst_dat3", bus3.dat_rd, 32'h0);

    // Fill both memories with known contents through long linear write bursts.
    burst(1'b0, 1'b1, 0, 2'b00, 1024, -1, 0, -1, 1'b0);
    burst(1'b1, 1'b1, 0, 2'b00, 1024, -1, 0, -1, 1'b0);

    for (int i = 0; i < 15; i++) begin
      classic(tbl[i].u, tbl[i].we, tbl[i].adr, tbl[i].sel, tbl[i].dat, 3'b000, ga, ge, gd, lat);
      $display("vec %0d u=%0d we=%0d adr=%h ack=%0d err=%0d dat=%h lat=%0d",
               i, tbl[i].u, tbl[i].we, tbl[i].adr, ga, ge, gd, lat);
      check("tv_ack", 32'(ga), 32'(!tbl[i].exp_err));
      check("tv_err", 32'(ge), 32'(tbl[i].exp_err));
      check("tv_lat", 32'(lat), 32'(2 + wait_of(tbl[i].u)));
      if (!tbl[i].we) check("tv_dat", gd, tbl[i].exp_dat);
      if (tbl[i].we && !tbl[i].exp_err) mwrite(tbl[i].u, int'(tbl[i].adr[31:2]), tbl[i].sel, tbl[i].dat);
    end

    // Wrap-4 read from word 6: words 6,7,4,5.
    burst(1'b0, 1'b0, 6, 2'b01, 4, -1, 0, -1, 1'b0);
    // Linear write of 8 beats with a 2-cycle strobe gap after beat 3, then read it back.
    burst(1'b0, 1'b1, 200, 2'b00, 8, 3, 2, -1, 1'b0);
    burst(1'b0, 1'b0, 200, 2'b00, 8, -1, 0, -1, 1'b0);
    // Linear bursts running past the last word.
    burst(1'b0, 1'b0, 1021, 2'b00, 5, -1, 0, -1, 1'b0);
    burst(1'b1, 1'b1, 1022, 2'b00, 4, -1, 0, -1, 1'b1);
    burst(1'b1, 1'b0, 1019, 2'b00, 5, -1, 0, -1, 1'b0);
    // Wrap-8 / wrap-16 on the wait-state instance.
    burst(1'b1, 1'b1, 45, 2'b10, 8, 2, 1, -1, 1'b1);
    burst(1'b1, 1'b0, 45, 2'b10, 8, -1, 0, -1, 1'b0);
    burst(1'b1, 1'b0, 77, 2'b11, 16, -1, 0, -1, 1'b0);
    // cti=111 on the first beat behaves as a single access.
    classic_model(1'b0, 1'b1, 32'h80, 4'hF, 32'hCAFEF00D, 3'b111);
    classic_model(1'b0, 1'b0, 32'h80, 4'hF, 32'h0, 3'b111);

    // Drop cyc while the W=3 instance is waiting on a write to word 8.
    use3 = 1'b1;
    tick();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; sel = 4'hF; dat = ~model[1][8]; cti = 3'b000;
    tick();
    tick();
    cyc = 1'b0; stb = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("abort_noack", 32'(ack | err), 32'h0);
    end
    $display("cyc drop during WAIT on word 8");
    classic_model(1'b1, 1'b0, 32'h20, 4'hF, 32'h0, 3'b000);

    // Reset during beat 3 of a linear write burst at word 300.
    burst(1'b0, 1'b1, 300, 2'b00, 8, -1, 0, 2, 1'b0);
    classic_model(1'b0, 1'b0, 32'(303 * 4), 4'hF, 32'h0, 3'b000);
    classic_model(1'b0, 1'b0, 32'(302 * 4), 4'hF, 32'h0, 3'b000);

    for (int i = 0; i < 30; i++) begin
      u = 1'($urandom);
      w = 1'($urandom);
      classic_model(u, w, 32'($urandom_range(0, 4500)), 4'($urandom), $urandom,
                    ($urandom_range(0, 3) == 0) ? 3'b111 : 3'b000);
    end

    for (int i = 0; i < 15; i++) begin
      u = 1'($urandom);
      w = 1'($urandom);
      b = 2'($urandom);
      n = $urandom_range(1, 16);
      st = (b == 2'b00) ? $urandom_range(0, 1030) : $urandom_range(0, 1023);
      g = (n > 2 && $urandom_range(0, 2) == 0) ? $urandom_range(0, n - 2) : -1;
      burst(u, w, st, b, n, g, $urandom_range(1, 3), -1, 1'b1);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
